uart_line_echo: RTL and testbench

//   Line-buffered echo controller that sits between the UART RX FIFO and the TX FIFO.

---
 rtl/uart_line_echo.sv | 116 +++++++++++
 tb/tb_uart_line_echo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_echo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_line_echo: buffers one RX line, echoes it offset by OFFSET, then EOL. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_line_echo #(
  parameter int          DEPTH  = 64,
  parameter int          ADDR_W = 6,
  parameter logic [7:0]  OFFSET = 8'h01,
  parameter logic [7:0]  EOL    = 8'h0D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_empty,
  input  logic [7:0]        rd_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        wr_data,
  output logic [ADDR_W:0]   line_len,
  output logic              busy,
  output logic              overflow
);

  localparam logic [1:0]      S_COLLECT  = 2'd0;
  localparam logic [1:0]      S_SEND     = 2'd1;
  localparam logic [1:0]      S_SEND_EOL = 2'd2;
  localparam logic [ADDR_W:0] C_DEPTH    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_ONE      = (ADDR_W+1)'(1);

  logic [1:0]      state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [ADDR_W:0] idx_q, idx_d;
  logic [ADDR_W:0] line_len_q, line_len_d;
  logic            mem_we;
  logic [7:0]      mem_rd;
  logic [7:0]      mem_q [DEPTH];

  // Strobes are gated by rst so nothing moves while reset is held.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    line_len_d = line_len_q;
    rd_uart    = 1'b0;
    wr_uart    = 1'b0;
    wr_data    = 8'h00;
    overflow   = 1'b0;
    busy       = 1'b0;
    mem_we     = 1'b0;
    mem_rd     = mem_q[idx_q[ADDR_W-1:0]];
    case (state_q)
      S_COLLECT: begin
        rd_uart = !rx_empty && !rst;
        if (rd_uart) begin
          if (rd_data == EOL) begin
            line_len_d = cnt_q;
            idx_d      = '0;
            state_d    = (cnt_q != '0) ? S_SEND : S_SEND_EOL;
          end else if (cnt_q < C_DEPTH) begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + C_ONE;
          end else begin
            overflow = 1'b1;
          end
        end
      end
      S_SEND: begin
        busy    = !rst;
        wr_uart = !tx_full && !rst;
        wr_data = mem_rd + OFFSET;
        if (wr_uart) begin
          idx_d = idx_q + C_ONE;
          if (idx_q == line_len_q - C_ONE) begin
            state_d = S_SEND_EOL;
          end
        end
      end
      S_SEND_EOL: begin
        busy    = !rst;
        wr_uart = !tx_full && !rst;
        wr_data = EOL;
        if (wr_uart) begin
          cnt_d   = '0;
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_COLLECT;
      cnt_q      <= '0;
      idx_q      <= '0;
      line_len_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      line_len_q <= line_len_d;
    end
  end

  // Line storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[cnt_q[ADDR_W-1:0]] <= rd_data;
    end
  end

  assign line_len = line_len_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_line_echo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_line_echo: scoreboard bench with RX/TX FIFO models.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_line_echo;

  localparam int         DEPTH  = 64;
  localparam int         ADDR_W = 6;
  localparam logic [7:0] OFFSET = 8'h01;
  localparam logic [7:0] EOL    = 8'h0D;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_empty = 1'b1;
  logic [7:0]        rd_data = 8'h00;
  logic              rd_uart;
  logic              tx_full = 1'b0;
  logic              wr_uart;
  logic [7:0]        wr_data;
  logic [ADDR_W:0]   line_len;
  logic              busy;
  logic              overflow;

  uart_line_echo #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OFFSET(OFFSET), .EOL(EOL)
  ) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rd_data(rd_data),
    .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart),
    .wr_data(wr_data), .line_len(line_len), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic       pop_pend      = 1'b0;
  int         tx_pushes     = 0;
  int         ovf_cnt       = 0;
  int         busy_cnt      = 0;
  int         stall_cnt     = 0;
  int         rst_left      = 3;
  int         rst_trigger   = -1;
  int         stall_left    = 0;
  int         stall_trigger = -1;
  int         exp_len       = 0;
  int         exp_ovf       = 0;

  // FIFO models: update on negedge, sample 1 time unit later.
  initial begin
    forever begin
      @(negedge clk);
      if (pop_pend) rx_q.delete(0);
      pop_pend = 1'b0;
      if (rst_trigger >= 0 && tx_pushes == rst_trigger) begin
        rst_left    = 2;
        rst_trigger = -1;
        exp_q.delete();
      end
      rst = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      if (stall_trigger >= 0 && tx_pushes == stall_trigger) begin
        stall_left    = 5;
        stall_trigger = -1;
      end
      tx_full = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      rx_empty = (rx_q.size() == 0);
      rd_data  = rx_empty ? 8'h00 : rx_q[0];
      #1;
      check("rd_and_wr", {31'd0, rd_uart & wr_uart}, 32'd0);
      check("rd_when_empty", {31'd0, rd_uart & rx_empty}, 32'd0);
      check("wr_when_full", {31'd0, wr_uart & tx_full}, 32'd0);
      if (rst) begin
        check("rst_strobes", {29'd0, rd_uart, wr_uart, busy}, 32'd0);
      end
      if (rd_uart) pop_pend = 1'b1;
      if (wr_uart) begin
        if (exp_q.size() == 0) check("tx_unexpected", {24'd0, wr_data}, 32'h100);
        else check("tx_data", {24'd0, wr_data}, {24'd0, exp_q.pop_front()});
        tx_pushes++;
      end
      if (overflow) ovf_cnt++;
      if (busy) busy_cnt++;
      if (tx_full && busy) stall_cnt++;
    end
  end

  task automatic push_line(input bq_t d);
    logic [7:0] t;
    int n = 0;
    exp_ovf = 0;
    foreach (d[i]) begin
      rx_q.push_back(d[i]);
      if (n < DEPTH) begin
        t = d[i] + OFFSET;
        exp_q.push_back(t);
        n++;
      end else begin
        exp_ovf++;
      end
    end
    rx_q.push_back(EOL);
    exp_q.push_back(EOL);
    exp_len = n;
  endtask

  task automatic start_line();
    @(posedge clk);
    #2;
    ovf_cnt   = 0;
    busy_cnt  = 0;
    stall_cnt = 0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      if (rx_q.size() == 0 && exp_q.size() == 0 && !busy && !pop_pend && !rst) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      check("idle_timeout", 32'd0, 32'd1);
      exp_q.delete();
      rx_q.delete();
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic run_line(input string tag, input bq_t d, input bit chk_busy);
    start_line();
    push_line(d);
    wait_idle();
    check({tag, "_line_len"}, {25'd0, line_len}, exp_len);
    check({tag, "_overflow"}, ovf_cnt, exp_ovf);
    if (chk_busy) check({tag, "_busy_cycles"}, busy_cnt, exp_len + 1);
  endtask

  initial begin
    bq_t d;
    int  base;
    rx_q.push_back(8'h5A);
    rx_q.push_back(EOL);
    exp_q.push_back(8'h5B);
    exp_q.push_back(EOL);
    #12;
    check("reset_rst_high", {31'd0, rst}, 32'd1);
    check("reset_rx_nonempty", {31'd0, rx_empty}, 32'd0);
    check("reset_line_len", {25'd0, line_len}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    check("reset_rd_uart", {31'd0, rd_uart}, 32'd0);
    wait_idle();
    check("preload_line_len", {25'd0, line_len}, 32'd1);

    d = {8'h41, 8'h42};
    run_line("ab", d, 1'b1);

    d = {};
    run_line("empty", d, 1'b1);

    d = {8'hFF};
    run_line("wrap", d, 1'b1);

    d = {};
    for (int i = 0; i < 70; i++) d.push_back(8'h20 + 8'(i));
    run_line("ovf", d, 1'b1);

    start_line();
    stall_trigger = tx_pushes + 2;
    d = {8'h61, 8'h62, 8'h63, 8'h64};
    push_line(d);
    d = {8'h70, 8'h71};
    push_line(d);
    wait_idle();
    check("stall_cycles", stall_cnt, 32'd5);
    check("stall_line_len", {25'd0, line_len}, 32'd2);
    check("stall_overflow", ovf_cnt, 32'd0);

    start_line();
    base = tx_pushes;
    rst_trigger = tx_pushes + 2;
    d = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    push_line(d);
    wait_idle();
    check("rst_mid_pushes", tx_pushes - base, 32'd2);
    check("rst_mid_line_len", {25'd0, line_len}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);

    d = {8'h78, 8'h79};
    run_line("after_rst", d, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
